button_cmd_ctrl: RTL and testbench
==================================

Name: button_cmd_ctrl

Overview:
- Converts the debounced user button (sync_debounce output) into camera-system commands.
- Classifies each press as short, double or long.
  - Short press: cycles the display mode.
  - Double press: toggles frame freeze.
  - Long press: requests an SCCB re-configuration from the camera config sequencer over a req/ack handshake.
- Sits between sync_debounce and the OV7670 capture/display/config blocks.

Parameters:
- LONG_CYC, 50_000_000 — hold cycles (btn_db high) that qualify a long press; must be ≥2.
- DBL_CYC, 25_000_000 — max gap cycles after release in which a second press makes a double; must be ≥2.
- NUM_MODES, 4 — number of display modes; must be ≥2.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- btn_db  in  1  debounced button level, 1 = pressed; already synchronous to Clk.
- mode  out  $clog2(NUM_MODES)  current display mode.
- freeze  out  1  frame-freeze enable (level).
- cfg_req  out  1  SCCB re-config request; held until acknowledged.
- cfg_ack  in  1  acknowledge from the config sequencer.
- evt_short  out  1  one-cycle pulse per short press.
- evt_double  out  1  one-cycle pulse per double press.
- evt_long  out  1  one-cycle pulse per long press.

Behaviour:

Reset (asynchronous, Reset=1):
- Outputs: mode=0, freeze=0, cfg_req=0, all evt_*=0.
- Internal: FSM=IDLE, cnt=0, btn_q=1.
- btn_q=1 means a button held through reset release produces no event until it is released and pressed again.
- Assertion mid-press or mid-gap aborts the classification; no event is emitted.

Edge detection:
- btn_q <= btn_db each cycle.
- rise = btn_db & ~btn_q; fall = ~btn_db & btn_q.

FSM states: IDLE, PRESS1, GAP, HOLD.
- IDLE:
  - rise -> PRESS1, cnt=0.
- PRESS1 (cnt increments each cycle while btn_db=1):
  - fall with cnt < LONG_CYC-1 -> GAP, cnt=0.
  - cnt == LONG_CYC-1 with btn_db=1 -> long event; -> HOLD.
- GAP (cnt increments each cycle):
  - rise -> double event; -> HOLD.
  - cnt == DBL_CYC-1 with no rise -> short event; -> IDLE.
  - If rise and cnt == DBL_CYC-1 occur in the same cycle, rise wins (double).
- HOLD:
  - Wait for btn_db=0, then -> IDLE.
  - No further events while in HOLD.

Counter:
- Width $clog2(max(LONG_CYC, DBL_CYC)).
- Never wraps; it is cleared on each state entry.

Event outputs:
- evt_* are registered and high exactly one cycle, on the clock edge after the decision cycle.
- Timing consequences:
  - Long: evt_long rises LONG_CYC+1 edges after the edge that sampled btn_db high.
  - Short: evt_short rises DBL_CYC+1 edges after the edge that sampled btn_db low.
- At most one evt_* is high in any cycle.

Actions (update on the same edge that raises the pulse):
- short: mode <= (mode == NUM_MODES-1) ? 0 : mode+1.
- double: freeze <= ~freeze; mode unchanged.
- long:
  - If cfg_req=0: cfg_req <= 1.
  - If cfg_req=1 (including the cycle cfg_ack is sampled): the request is dropped; evt_long still pulses.

cfg_req handshake:
- cfg_req stays high until cfg_ack is sampled high, then goes low on the next edge.
- cfg_ack while cfg_req=0 is ignored.
- cfg_ack may stay high for multiple cycles; it has no effect after cfg_req falls.

Decomposition:
- Package btn_cmd_pkg holds:
  - typedef enum logic [1:0] press_state_t {IDLE, PRESS1, GAP, HOLD};
  - typedef enum press_evt_t {EVT_NONE, EVT_SHORT, EVT_DOUBLE, EVT_LONG}.
- Sub-module press_classifier:
  - Contains the edge detect, FSM and counter.
  - Emits press_evt_t plus a one-cycle valid.
- The top level holds the mode/freeze registers, cfg_req handshake logic and evt_* pulse registers.

Test Plan:
All scenarios use LONG_CYC=16, DBL_CYC=8, NUM_MODES=3.
1. Reset and held button: hold btn_db=1 through Reset release, keep it high 40 cycles -> all outputs stay 0, no evt_*. Release, then press 4 cycles -> evt_short, mode=1.
2. Short presses and wrap: three presses (4 high / 12 low) -> mode 1, 2, 0. Each evt_short rises exactly 9 edges after the sampled fall; freeze=0 throughout.
3. Double press: high 4, low 3, high 4, low -> evt_double once, freeze 0->1, mode unchanged, no evt_short. Repeat -> freeze=0.
4. Long-press boundary: hold exactly 15 cycles -> short event, mode+1. Hold exactly 16 cycles -> evt_long 17 edges after the sampled rise, cfg_req=1, mode unchanged.
5. cfg_req handshake: long press with cfg_ack=0 -> cfg_req high for 30 cycles. A second long press meanwhile -> evt_long pulses, cfg_req stays high (no queued request). cfg_ack=1 for 1 cycle -> cfg_req=0 on the next edge. A third long press -> cfg_req=1 again.
6. Reset mid-operation: assert Reset 3 cycles into GAP -> mode=0, freeze=0, cfg_req=0, no evt_*. Post-reset short press -> mode=1.

Source files
------------

// File: rtl/btn_cmd_pkg.sv
// Shared types for the button command controller: press-classifier FSM states,
// classified press events and the classifier-to-top event payload.
package btn_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS1,
    GAP,
    HOLD
  } press_state_t;

  typedef enum logic [1:0] {
    EVT_NONE,
    EVT_SHORT,
    EVT_DOUBLE,
    EVT_LONG
  } press_evt_t;

  typedef struct packed {
    logic       valid;
    press_evt_t evt;
  } press_event_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced button activity into short, double and long presses.
// Emits one registered event with a single-cycle valid per classified press.
module press_classifier
  import btn_cmd_pkg::*;
#(
  parameter int unsigned LONG_CYC = 50_000_000,
  parameter int unsigned DBL_CYC  = 25_000_000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         btn_db_i,
  output press_event_t press_o
);

  localparam int unsigned      CNT_W     = $clog2(max_u(LONG_CYC, DBL_CYC));
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

  press_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q;
  press_event_t     press_q, press_d;
  logic             rise_c, fall_c;

  assign rise_c  = btn_db_i & ~btn_q;
  assign fall_c  = ~btn_db_i & btn_q;
  assign press_o = press_q;

  // btn_q resets high so a button held through reset needs a fresh press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      btn_q   <= 1'b1;
      press_q <= '{valid: 1'b0, evt: EVT_NONE};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn_db_i;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    press_d.valid = 1'b0;
    press_d.evt   = EVT_NONE;

    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end

      // Reaching the last hold count qualifies as long even if released that cycle.
      PRESS1: begin
        if (cnt_q == LONG_LAST) begin
          state_d       = HOLD;
          cnt_d         = '0;
          press_d.valid = 1'b1;
          press_d.evt   = EVT_LONG;
        end else if (fall_c) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (btn_db_i) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A second rise beats gap expiry when both land in the same cycle.
      GAP: begin
        if (rise_c) begin
          state_d       = HOLD;
          cnt_d         = '0;
          press_d.valid = 1'b1;
          press_d.evt   = EVT_DOUBLE;
        end else if (cnt_q == DBL_LAST) begin
          state_d       = IDLE;
          cnt_d         = '0;
          press_d.valid = 1'b1;
          press_d.evt   = EVT_SHORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HOLD: begin
        if (!btn_db_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_cmd_ctrl.sv
// Turns classified button presses into camera commands: display-mode cycling,
// frame-freeze toggling and an SCCB re-configuration req/ack handshake.
module button_cmd_ctrl
  import btn_cmd_pkg::*;
#(
  parameter int unsigned LONG_CYC  = 50_000_000,
  parameter int unsigned DBL_CYC   = 25_000_000,
  parameter int unsigned NUM_MODES = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         btn_db,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic                         freeze,
  output logic                         cfg_req,
  input  logic                         cfg_ack,
  output logic                         evt_short,
  output logic                         evt_double,
  output logic                         evt_long
);

  localparam int unsigned       MODE_W    = $clog2(NUM_MODES);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

  press_event_t      press;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              freeze_q, freeze_d;
  logic              cfg_req_q, cfg_req_d;
  logic              evt_short_q, evt_short_d;
  logic              evt_double_q, evt_double_d;
  logic              evt_long_q, evt_long_d;

  press_classifier #(
    .LONG_CYC (LONG_CYC),
    .DBL_CYC  (DBL_CYC)
  ) u_press_classifier (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .btn_db_i (btn_db),
    .press_o  (press)
  );

  assign mode       = mode_q;
  assign freeze     = freeze_q;
  assign cfg_req    = cfg_req_q;
  assign evt_short  = evt_short_q;
  assign evt_double = evt_double_q;
  assign evt_long   = evt_long_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mode_q       <= '0;
      freeze_q     <= 1'b0;
      cfg_req_q    <= 1'b0;
      evt_short_q  <= 1'b0;
      evt_double_q <= 1'b0;
      evt_long_q   <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      freeze_q     <= freeze_d;
      cfg_req_q    <= cfg_req_d;
      evt_short_q  <= evt_short_d;
      evt_double_q <= evt_double_d;
      evt_long_q   <= evt_long_d;
    end
  end

  always_comb begin
    mode_d       = mode_q;
    freeze_d     = freeze_q;
    cfg_req_d    = cfg_req_q;
    evt_short_d  = 1'b0;
    evt_double_d = 1'b0;
    evt_long_d   = 1'b0;

    if (press.valid) begin
      case (press.evt)
        EVT_SHORT: begin
          evt_short_d = 1'b1;
          mode_d      = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
        end
        EVT_DOUBLE: begin
          evt_double_d = 1'b1;
          freeze_d     = ~freeze_q;
        end
        EVT_LONG: begin
          evt_long_d = 1'b1;
        end
        default: begin
          evt_short_d = 1'b0;
        end
      endcase
    end

    // An outstanding request only waits for ack; long presses meanwhile are not queued.
    if (cfg_req_q) begin
      cfg_req_d = ~cfg_ack;
    end else if (press.valid && (press.evt == EVT_LONG)) begin
      cfg_req_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_button_cmd_ctrl.sv
// Self-checking bench for button_cmd_ctrl: directed segment table, exact-timing
// sequences, reset corner cases and a randomized run against a press-level model.
module tb_button_cmd_ctrl;

  localparam int unsigned LONG_CYC  = 16;
  localparam int unsigned DBL_CYC   = 8;
  localparam int unsigned NUM_MODES = 3;
  localparam int          N_RAND    = 3000;
  localparam int          NT        = 29;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       btn_db;
  logic       cfg_ack;
  logic [1:0] mode;
  logic       freeze;
  logic       cfg_req;
  logic       evt_short;
  logic       evt_double;
  logic       evt_long;

  int n_checks = 0;
  int n_fail   = 0;
  int c_s, c_d, c_l;

  typedef struct {
    logic        btn;
    logic        ack;
    int unsigned cyc;
    int unsigned mode;
    int unsigned fz;
    int unsigned cfg;
    int unsigned ns;
    int unsigned nd;
    int unsigned nl;
  } seg_t;

  seg_t tbl [NT];

  bit          s_btn [N_RAND];
  bit          s_ack [N_RAND];
  int unsigned e_evt [N_RAND];
  logic [6:0]  e_out [N_RAND];
  int          hs [10] = '{1, 2, 3, 4, 5, 14, 15, 16, 17, 22};
  int          gs [8]  = '{1, 2, 3, 7, 8, 9, 10, 14};

  button_cmd_ctrl #(
    .LONG_CYC  (LONG_CYC),
    .DBL_CYC   (DBL_CYC),
    .NUM_MODES (NUM_MODES)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .btn_db     (btn_db),
    .mode       (mode),
    .freeze     (freeze),
    .cfg_req    (cfg_req),
    .cfg_ack    (cfg_ack),
    .evt_short  (evt_short),
    .evt_double (evt_double),
    .evt_long   (evt_long)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run(input int cyc);
    c_s = 0;
    c_d = 0;
    c_l = 0;
    repeat (cyc) begin
      tick();
      c_s += int'(evt_short);
      c_d += int'(evt_double);
      c_l += int'(evt_long);
    end
  endtask

  task automatic wait_evt(input int which, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 40) begin
      tick();
      n++;
      hit = (which == 0) ? evt_short : (which == 1) ? evt_double : evt_long;
    end
  endtask

  task automatic do_reset(input logic btn_level);
    btn_db  = btn_level;
    cfg_ack = 1'b0;
    Reset   = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check("reset_outputs", 32'({mode, freeze, cfg_req, evt_short, evt_double, evt_long}), 32'd0);
  endtask

  // Press-level model: events derived from press/gap lengths, not cycle-by-cycle state.
  task automatic build_random();
    int r, f, h, g, cur;
    bit swallow, prev, cq, fz;
    int unsigned m;
    bit es, ed, el;
    for (int k = 0; k < N_RAND; k++) begin
      s_btn[k] = 1'b0;
      s_ack[k] = ($urandom_range(0, 7) == 0);
      e_evt[k] = 0;
    end
    cur     = 3;
    swallow = 1'b0;
    while (cur < N_RAND - 60) begin
      h = hs[$urandom_range(0, 9)];
      g = gs[$urandom_range(0, 7)];
      r = cur;
      f = r + h;
      for (int k = r; k < f; k++) s_btn[k] = 1'b1;
      if (swallow) begin
        swallow = 1'b0;
      end else if (h >= int'(LONG_CYC)) begin
        e_evt[r + int'(LONG_CYC) + 1] = 3;
        swallow = (h == int'(LONG_CYC)) && (g == 1);
      end else if (g <= int'(DBL_CYC)) begin
        e_evt[f + g + 1] = 2;
        swallow = 1'b1;
      end else begin
        e_evt[f + int'(DBL_CYC) + 1] = 1;
      end
      cur = f + g;
    end
    m  = 0;
    fz = 1'b0;
    cq = 1'b0;
    for (int t = 0; t < N_RAND; t++) begin
      prev = cq;
      es = (e_evt[t] == 1);
      ed = (e_evt[t] == 2);
      el = (e_evt[t] == 3);
      if (es) m = (m + 1) % NUM_MODES;
      if (ed) fz = !fz;
      cq = prev ? !s_ack[t] : el;
      e_out[t] = {2'(m), fz, cq, es, ed, el};
    end
  endtask

  initial begin
    int n;

    tbl[0]  = '{1'b0, 1'b0, 3,  0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 4,  0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 12, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 4,  1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 12, 2, 0, 0, 1, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 4,  2, 0, 0, 0, 0, 0};
    tbl[6]  = '{1'b0, 1'b0, 12, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{1'b1, 1'b0, 4,  0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 3,  0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 4,  0, 1, 0, 0, 1, 0};
    tbl[10] = '{1'b0, 1'b0, 12, 0, 1, 0, 0, 0, 0};
    tbl[11] = '{1'b1, 1'b0, 4,  0, 1, 0, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 3,  0, 1, 0, 0, 0, 0};
    tbl[13] = '{1'b1, 1'b0, 4,  0, 0, 0, 0, 1, 0};
    tbl[14] = '{1'b0, 1'b0, 12, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{1'b1, 1'b0, 15, 0, 0, 0, 0, 0, 0};
    tbl[16] = '{1'b0, 1'b0, 12, 1, 0, 0, 1, 0, 0};
    tbl[17] = '{1'b1, 1'b0, 16, 1, 0, 0, 0, 0, 0};
    tbl[18] = '{1'b0, 1'b0, 30, 1, 0, 1, 0, 0, 1};
    tbl[19] = '{1'b1, 1'b0, 20, 1, 0, 1, 0, 0, 1};
    tbl[20] = '{1'b0, 1'b0, 4,  1, 0, 1, 0, 0, 0};
    tbl[21] = '{1'b0, 1'b1, 1,  1, 0, 0, 0, 0, 0};
    tbl[22] = '{1'b0, 1'b0, 3,  1, 0, 0, 0, 0, 0};
    tbl[23] = '{1'b1, 1'b0, 20, 1, 0, 1, 0, 0, 1};
    tbl[24] = '{1'b0, 1'b0, 4,  1, 0, 1, 0, 0, 0};
    tbl[25] = '{1'b0, 1'b1, 3,  1, 0, 0, 0, 0, 0};
    tbl[26] = '{1'b1, 1'b1, 18, 1, 0, 1, 0, 0, 1};
    tbl[27] = '{1'b1, 1'b1, 2,  1, 0, 0, 0, 0, 0};
    tbl[28] = '{1'b0, 1'b0, 6,  1, 0, 0, 0, 0, 0};

    // Button held through reset release must stay silent until re-pressed.
    do_reset(1'b1);
    run(40);
    check("held_no_evt", 32'(c_s + c_d + c_l), 32'd0);
    check("held_outputs", 32'({mode, freeze, cfg_req}), 32'd0);
    btn_db = 1'b0;
    run(12);
    btn_db = 1'b1;
    run(4);
    btn_db = 1'b0;
    run(12);
    check("held_then_short_cnt", 32'(c_s), 32'd1);
    check("held_then_short_mode", 32'(mode), 32'd1);

    do_reset(1'b0);
    for (int i = 0; i < NT; i++) begin
      btn_db  = tbl[i].btn;
      cfg_ack = tbl[i].ack;
      run(int'(tbl[i].cyc));
      check($sformatf("row%0d_mode", i),   32'(mode),    32'(tbl[i].mode));
      check($sformatf("row%0d_freeze", i), 32'(freeze),  32'(tbl[i].fz));
      check($sformatf("row%0d_cfg_req", i), 32'(cfg_req), 32'(tbl[i].cfg));
      check($sformatf("row%0d_n_short", i), 32'(c_s),    32'(tbl[i].ns));
      check($sformatf("row%0d_n_double", i), 32'(c_d),   32'(tbl[i].nd));
      check($sformatf("row%0d_n_long", i), 32'(c_l),     32'(tbl[i].nl));
    end

    // Exact pulse latencies relative to the sampling edge.
    do_reset(1'b0);
    run(2);
    btn_db = 1'b1;
    run(4);
    btn_db = 1'b0;
    tick();
    wait_evt(0, n);
    check("short_latency", 32'(n), 32'(DBL_CYC + 1));
    run(4);
    btn_db = 1'b1;
    tick();
    wait_evt(2, n);
    check("long_latency", 32'(n), 32'(LONG_CYC + 1));
    check("long_sets_cfg_req", 32'(cfg_req), 32'd1);
    btn_db = 1'b0;
    run(4);
    btn_db = 1'b1;
    run(4);
    btn_db = 1'b0;
    run(3);
    btn_db = 1'b1;
    tick();
    wait_evt(1, n);
    check("double_latency", 32'(n), 32'd1);
    btn_db = 1'b0;
    run(4);
    check("pre_abort_state", 32'({mode, freeze, cfg_req}), 32'({2'd1, 1'b1, 1'b1}));

    // Reset in the middle of the gap aborts the pending short press.
    btn_db = 1'b1;
    run(4);
    btn_db = 1'b0;
    run(4);
    Reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'({mode, freeze, cfg_req, evt_short, evt_double, evt_long}), 32'd0);
    tick();
    Reset = 1'b0;
    run(20);
    check("abort_no_evt", 32'(c_s + c_d + c_l), 32'd0);
    check("abort_outputs", 32'({mode, freeze, cfg_req}), 32'd0);
    btn_db = 1'b1;
    run(4);
    btn_db = 1'b0;
    run(12);
    check("post_abort_short_cnt", 32'(c_s), 32'd1);
    check("post_abort_mode", 32'(mode), 32'd1);

    build_random();
    do_reset(1'b0);
    for (int t = 0; t < N_RAND; t++) begin
      btn_db  = s_btn[t];
      cfg_ack = s_ack[t];
      tick();
      check($sformatf("rand_cyc%0d", t),
            32'({mode, freeze, cfg_req, evt_short, evt_double, evt_long}), 32'(e_out[t]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
